// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 core: wait-stated word RAM with a one-cycle
// memRDY strobe, range checking, and a side-band preload port usable while idle.
module lc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              memWE,
    input  logic [15:0]       memory_addr,
    input  logic [15:0]       memory_din,
    output logic [15:0]       memory_dout,
    output logic              memRDY,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic       HAS_WAIT  = (WAIT_STATES > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Address bits above the implemented RAM must all be zero.
    function automatic logic addr_in_range(input logic [15:0] a);
        addr_in_range = ((a >> ADDR_W) == 16'h0000);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              capture_s;
    logic [15:0]       req_addr_r;
    logic [15:0]       req_din_r;
    logic              req_we_r;
    logic              req_in_range_s;
    logic              resp_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [15:0]       ram_wdata_s;
    logic [15:0]       memory_dout_r;
    logic              mem_rdy_r;
    logic              busy_r;
    logic              err_r;
    logic [15:0]       mem_r [DEPTH];

    assign req_in_range_s = addr_in_range(req_addr_r);
    assign resp_s         = (state_r == ST_RESP);

    assign memory_dout = memory_dout_r;
    assign memRDY      = mem_rdy_r;
    assign busy        = busy_r;
    assign err         = err_r;

    // Next-state and wait-counter logic; preload has priority over a CPU request.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (memEN && !load_en) begin
                    capture_s = 1'b1;
                    cnt_s     = WAIT_LOAD;
                    state_s   = HAS_WAIT ? ST_WAIT : ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_RESP;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request registers: CPU inputs are sampled only at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_r <= 16'h0000;
            req_din_r  <= 16'h0000;
            req_we_r   <= 1'b0;
        end else if (capture_s) begin
            req_addr_r <= memory_addr;
            req_din_r  <= memory_din;
            req_we_r   <= memWE;
        end else begin
            req_addr_r <= req_addr_r;
            req_din_r  <= req_din_r;
            req_we_r   <= req_we_r;
        end
    end

    // Single RAM write port shared by preload (IDLE only) and CPU writes (RESP only).
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = {ADDR_W{1'b0}};
        ram_wdata_s = 16'h0000;
        if (rst) begin
            ram_we_s = 1'b0;
        end else if ((state_r == ST_IDLE) && load_en) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = load_addr;
            ram_wdata_s = load_data;
        end else if (resp_s && req_we_r && req_in_range_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = req_addr_r[ADDR_W-1:0];
            ram_wdata_s = req_din_r;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // RAM array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Registered outputs: the RESP edge launches memRDY, err and read data together.
    always_ff @(posedge clk) begin
        if (rst) begin
            memory_dout_r <= 16'h0000;
            mem_rdy_r     <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            mem_rdy_r <= resp_s;
            err_r     <= resp_s && !req_in_range_s;
            busy_r    <= (state_s != ST_IDLE);
            if (resp_s && !req_we_r) begin
                memory_dout_r <= req_in_range_s ? mem_r[req_addr_r[ADDR_W-1:0]] : 16'h0000;
            end else begin
                memory_dout_r <= memory_dout_r;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: three builds (14-bit/2 waits, 10-bit/2 waits,
// 10-bit/0 waits) share one stimulus stream; each output set is checked separately.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memEN;
    logic        memWE;
    logic [15:0] addr;
    logic [15:0] din;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;

    logic [15:0] dout_a, dout_b, dout_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_W(14), .WAIT_STATES(2)) u_a (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
        .memory_addr(addr), .memory_din(din), .memory_dout(dout_a), .memRDY(rdy_a),
        .load_en(load_en), .load_addr(load_addr[13:0]), .load_data(load_data),
        .busy(busy_a), .err(err_a)
    );

    lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(2)) u_b (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
        .memory_addr(addr), .memory_din(din), .memory_dout(dout_b), .memRDY(rdy_b),
        .load_en(load_en), .load_addr(load_addr[9:0]), .load_data(load_data),
        .busy(busy_b), .err(err_b)
    );

    lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_c (
        .clk(clk), .rst(rst), .memEN(memEN), .memWE(memWE),
        .memory_addr(addr), .memory_din(din), .memory_dout(dout_c), .memRDY(rdy_c),
        .load_en(load_en), .load_addr(load_addr[9:0]), .load_data(load_data),
        .busy(busy_c), .err(err_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // One CPU access on build B: hold memEN until memRDY (bounded), then release.
    task automatic b_access(input string tag, input logic we, input logic [15:0] a,
                            input logic [15:0] d, output int lat,
                            output logic [15:0] rdata, output logic e);
        memEN = 1'b1;
        memWE = we;
        addr  = a;
        din   = d;
        lat   = 0;
        do begin
            tick();
            lat++;
        end while (rdy_b !== 1'b1 && lat < 10);
        rdata = dout_b;
        e     = err_b;
        memEN = 1'b0;
        memWE = 1'b0;
        tick();
        chk1({tag, "_pulse_width"}, rdy_b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        e;
        logic        seen;

        rst = 1'b1; memEN = 1'b0; memWE = 1'b0; addr = 16'h0000; din = 16'h0000;
        load_en = 1'b0; load_addr = 16'h0000; load_data = 16'h0000;
        tick();
        tick();
        chk1("rst_rdy_a", rdy_a, 1'b0);
        chk1("rst_busy_a", busy_a, 1'b0);
        chk1("rst_err_b", err_b, 1'b0);
        chk16("rst_dout_b", dout_b, 16'h0000);
        rst = 1'b0;

        // 1: preload + read 0x3000 on the 14-bit build; build B sees it out of range.
        preload(16'h3000, 16'hBEEF);
        memEN = 1'b1; memWE = 1'b0; addr = 16'h3000;
        tick();
        chk1("t1_busy_e1", busy_a, 1'b1);
        chk1("t1_rdy_e1", rdy_a, 1'b0);
        tick();
        chk1("t1_busy_e2", busy_a, 1'b1);
        chk1("t1_rdy_e2", rdy_a, 1'b0);
        tick();
        chk1("t1_busy_resp", busy_a, 1'b1);
        chk1("t1_rdy_e3", rdy_a, 1'b0);
        tick();
        chk1("t1_rdy_e4", rdy_a, 1'b1);
        chk16("t1_dout", dout_a, 16'hBEEF);
        chk1("t1_err", err_a, 1'b0);
        chk1("t1_busy_done", busy_a, 1'b0);
        chk1("t1_b_err", err_b, 1'b1);
        chk16("t1_b_dout", dout_b, 16'h0000);
        memEN = 1'b0;
        tick();
        chk1("t1_rdy_single", rdy_a, 1'b0);
        chk1("t1_err_single", err_a, 1'b0);

        // 2: write then read back 0x0010.
        b_access("t2_wr", 1'b1, 16'h0010, 16'h1234, lat, rd, e);
        chk_int("t2_wr_latency", lat, 4);
        chk1("t2_wr_err", e, 1'b0);
        chk16("t2_wr_dout_hold", rd, 16'h0000);
        b_access("t2_rd", 1'b0, 16'h0010, 16'h0000, lat, rd, e);
        chk_int("t2_rd_latency", lat, 4);
        chk16("t2_rd_data", rd, 16'h1234);
        chk1("t2_rd_err", e, 1'b0);

        // 3: out-of-range write dropped (would alias RAM[0]), out-of-range read returns 0.
        b_access("t3_wr", 1'b1, 16'h8000, 16'hFFFF, lat, rd, e);
        chk1("t3_wr_err", e, 1'b1);
        chk16("t3_wr_dout_hold", rd, 16'h1234);
        b_access("t3_rd_oor", 1'b0, 16'hFE00, 16'h0000, lat, rd, e);
        chk1("t3_rd_err", e, 1'b1);
        chk16("t3_rd_data", rd, 16'h0000);
        b_access("t3_rd0", 1'b0, 16'h0000, 16'h0000, lat, rd, e);
        chk16("t3_ram0_unchanged", rd, 16'hBEEF);
        chk1("t3_rd0_err", e, 1'b0);

        // 5: reset during WAIT of a write aborts it.
        preload(16'h0005, 16'h5555);
        memEN = 1'b1; memWE = 1'b1; addr = 16'h0005; din = 16'hAAAA;
        tick();
        chk1("t5_busy_capture", busy_b, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk1("t5_busy_after_rst", busy_b, 1'b0);
        chk1("t5_rdy_after_rst", rdy_b, 1'b0);
        chk16("t5_dout_after_rst", dout_b, 16'h0000);
        rst = 1'b0; memEN = 1'b0; memWE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | rdy_b;
        end
        chk1("t5_no_rdy", seen, 1'b0);
        b_access("t5_rd", 1'b0, 16'h0005, 16'h0000, lat, rd, e);
        chk16("t5_ram5_unchanged", rd, 16'h5555);

        // 6: preload beats a simultaneous CPU request; preload during WAIT is ignored.
        memEN = 1'b1; memWE = 1'b0; addr = 16'h0020;
        load_en = 1'b1; load_addr = 16'h0020; load_data = 16'hCAFE;
        tick();
        chk1("t6_no_capture", busy_b, 1'b0);
        load_en = 1'b0;
        b_access("t6_rd", 1'b0, 16'h0020, 16'h0000, lat, rd, e);
        chk_int("t6_deferred_latency", lat, 4);
        chk16("t6_rd_data", rd, 16'hCAFE);
        memEN = 1'b1; memWE = 1'b0; addr = 16'h0020;
        tick();
        chk1("t6_busy_wait", busy_b, 1'b1);
        load_en = 1'b1; load_addr = 16'h0020; load_data = 16'hDEAD;
        tick();
        load_en = 1'b0;
        tick();
        tick();
        chk1("t6_rdy", rdy_b, 1'b1);
        chk16("t6_rd_during_load", dout_b, 16'hCAFE);
        memEN = 1'b0;
        tick();
        b_access("t6_rd2", 1'b0, 16'h0020, 16'h0000, lat, rd, e);
        chk16("t6_ram_unchanged", rd, 16'hCAFE);

        // 4: zero-wait build, single access then continuous memEN.
        rst = 1'b1;
        tick();
        chk16("t4_rst_dout", dout_c, 16'h0000);
        chk1("t4_rst_busy", busy_c, 1'b0);
        rst = 1'b0;
        preload(16'h0030, 16'h1357);
        memEN = 1'b1; memWE = 1'b0; addr = 16'h0030;
        tick();
        chk1("t4_busy_e1", busy_c, 1'b1);
        chk1("t4_rdy_e1", rdy_c, 1'b0);
        tick();
        chk1("t4_rdy_e2", rdy_c, 1'b1);
        chk16("t4_dout", dout_c, 16'h1357);
        chk1("t4_err", err_c, 1'b0);
        chk1("t4_busy_e2", busy_c, 1'b0);
        tick();
        chk1("t4_rdy_e3", rdy_c, 1'b0);
        chk1("t4_busy_e3", busy_c, 1'b1);
        tick();
        chk1("t4_rdy_e4", rdy_c, 1'b1);
        memEN = 1'b0;
        tick();
        chk1("t4_rdy_e5", rdy_c, 1'b0);
        tick();
        chk1("t4_rdy_e6", rdy_c, 1'b0);
        chk1("t4_busy_e6", busy_c, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
